// File: rtl/rans_enc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rans_enc_ctrl_pkg
// Description : Shared types for the rANS frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rans_enc_ctrl_pkg;

    localparam int RESOLUTION   = 10;
    localparam int SYMBOL_WIDTH = 8;
    localparam int MAX_FRAME    = 1024;

    typedef logic [RESOLUTION:0]   freq_t;
    typedef logic [RESOLUTION-1:0] cum_t;

    typedef struct packed {
        freq_t freq;
        cum_t  cum;
    } tbl_entry_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        DRAIN     = 3'd2,
        WAIT_DONE = 3'd3,
        DISCARD   = 3'd4
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/rans_enc_ctrl_stack.sv
`default_nettype none
// ============================================================================
// Module      : rans_sym_stack
// Description : LIFO of table entries; replays a frame last-to-first.
// Revision    : 1.0 - initial release
// ============================================================================
module rans_sym_stack #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_at_bottom
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;

    assign w_wr_idx    = ptr_q[AW-1:0];
    assign w_top_idx   = ptr_q[AW-1:0] - AW'(1);
    assign o_top       = mem_q[w_top_idx];
    assign o_empty     = (ptr_q == '0);
    assign o_at_bottom = (ptr_q == PW'(1));

    always_comb begin
        ptr_d = ptr_q;
        if (i_clear) begin
            ptr_d = '0;
        end else if (i_push) begin
            ptr_d = ptr_q + PW'(1);
        end else if (i_pop) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            mem_q[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_push && i_pop));
        end
    end

endmodule
`default_nettype wire

// File: rtl/rans_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rans_enc_ctrl
// Description : Frame sequencer in front of the rANS encoder core.
// Revision    : 1.0 - initial release
// ============================================================================
module rans_enc_ctrl
    import rans_enc_ctrl_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int MAX_FRAME    = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [SYMBOL_WIDTH-1:0]          cfg_sym,
    input  logic [RESOLUTION:0]              cfg_freq,
    input  logic [RESOLUTION-1:0]            cfg_cum,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [SYMBOL_WIDTH-1:0]          s_sym,
    input  logic                             s_last,
    output logic                             core_valid,
    input  logic                             core_ready,
    output logic [RESOLUTION:0]              core_freq,
    output logic [RESOLUTION-1:0]            core_cum,
    output logic                             core_first,
    output logic                             core_last,
    input  logic                             core_done,
    output logic                             busy,
    output logic [$clog2(MAX_FRAME+1)-1:0]   frame_len,
    output logic                             err_zero,
    output logic                             err_ovf
);

    localparam int ENTRY_W   = 2 * RESOLUTION + 1;
    localparam int LEN_W     = $clog2(MAX_FRAME + 1);
    localparam int TBL_DEPTH = 1 << SYMBOL_WIDTH;
    localparam logic [LEN_W-1:0] C_LEN_OVF = LEN_W'(MAX_FRAME + 1);

    ctrl_state_t        state_q;
    ctrl_state_t        state_d;
    logic [LEN_W-1:0]   frame_len_q;
    logic [LEN_W-1:0]   frame_len_d;
    logic               err_zero_q;
    logic               err_zero_d;
    logic               err_ovf_q;
    logic               err_ovf_d;
    logic               first_q;
    logic               first_d;

    logic [ENTRY_W-1:0] tbl_q [TBL_DEPTH];
    logic [ENTRY_W-1:0] w_lookup;
    logic [ENTRY_W-1:0] w_top;
    logic [LEN_W-1:0]   w_len_base;
    logic [LEN_W-1:0]   w_len_inc;
    logic               w_zero_freq;
    logic               w_len_ovf;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;
    logic               w_empty;
    logic               w_at_bottom;
    logic               w_in_drain;

    assign w_lookup    = tbl_q[s_sym];
    assign w_zero_freq = (w_lookup[ENTRY_W-1 -: RESOLUTION+1] == '0);

    // The first beat of a frame counts from zero, not from the previous frame's length.
    assign w_len_base  = (state_q == IDLE) ? '0 : frame_len_q;
    assign w_len_inc   = (w_len_base == C_LEN_OVF) ? w_len_base : w_len_base + LEN_W'(1);
    assign w_len_ovf   = (w_len_inc == C_LEN_OVF);

    assign w_in_drain  = (state_q == DRAIN) && !w_empty;
    assign core_valid  = w_in_drain;
    assign core_freq   = w_in_drain ? w_top[ENTRY_W-1 -: RESOLUTION+1] : '0;
    assign core_cum    = w_in_drain ? w_top[RESOLUTION-1:0] : '0;
    assign core_first  = w_in_drain && first_q;
    assign core_last   = w_in_drain && w_at_bottom;
    assign s_ready     = (state_q == IDLE) || (state_q == FILL) || (state_q == DISCARD);
    assign busy        = (state_q != IDLE);
    assign frame_len   = frame_len_q;
    assign err_zero    = err_zero_q;
    assign err_ovf     = err_ovf_q;

    rans_sym_stack #(
        .WIDTH (ENTRY_W),
        .DEPTH (MAX_FRAME)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .i_data      (w_lookup),
        .o_top       (w_top),
        .o_empty     (w_empty),
        .o_at_bottom (w_at_bottom)
    );

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        err_zero_d  = err_zero_q;
        err_ovf_d   = err_ovf_q;
        first_d     = first_q;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                if (s_valid) begin
                    frame_len_d = w_len_inc;
                    err_zero_d  = (state_q == FILL) ? err_zero_q : 1'b0;
                    err_ovf_d   = (state_q == FILL) ? err_ovf_q  : 1'b0;
                    if (w_zero_freq || w_len_ovf) begin
                        err_zero_d = err_zero_d | w_zero_freq;
                        err_ovf_d  = err_ovf_d  | w_len_ovf;
                        w_clear    = 1'b1;
                        state_d    = s_last ? IDLE : DISCARD;
                    end else begin
                        w_push  = 1'b1;
                        first_d = 1'b1;
                        state_d = s_last ? DRAIN : FILL;
                    end
                end
            end
            DISCARD: begin
                if (s_valid) begin
                    frame_len_d = w_len_inc;
                    if (s_last) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (w_in_drain && core_ready) begin
                    w_pop   = 1'b1;
                    first_d = 1'b0;
                    if (w_at_bottom) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_len_q <= '0;
            err_zero_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            err_zero_q  <= err_zero_d;
            err_ovf_q   <= err_ovf_d;
            first_q     <= first_d;
        end
    end

    // Table survives reset so software need not reprogram after an abort.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == IDLE)) begin
            tbl_q[cfg_sym] <= {cfg_freq, cfg_cum};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rans_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rans_enc_ctrl
// Description : Self-checking bench for rans_enc_ctrl using a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rans_enc_ctrl;

    localparam int RES = 10;
    localparam int SW  = 8;
    localparam int MF  = 1024;
    localparam int LW  = 11;
    localparam logic [63:0] X0 = 64'd65536;
    localparam logic [7:0] SYM_A = 8'h41;
    localparam logic [7:0] SYM_B = 8'h42;
    localparam logic [7:0] SYM_C = 8'h43;
    localparam logic [7:0] SYM_D = 8'h44;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_we = 1'b0;
    logic [SW-1:0]  cfg_sym = '0;
    logic [RES:0]   cfg_freq = '0;
    logic [RES-1:0] cfg_cum = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [SW-1:0]  s_sym = '0;
    logic           s_last = 1'b0;
    logic           core_valid;
    logic           core_ready = 1'b1;
    logic [RES:0]   core_freq;
    logic [RES-1:0] core_cum;
    logic           core_first;
    logic           core_last;
    logic           core_done = 1'b0;
    logic           busy;
    logic [LW-1:0]  frame_len;
    logic           err_zero;
    logic           err_ovf;

    rans_enc_ctrl #(
        .RESOLUTION   (RES),
        .SYMBOL_WIDTH (SW),
        .MAX_FRAME    (MF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_sym    (cfg_sym),
        .cfg_freq   (cfg_freq),
        .cfg_cum    (cfg_cum),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sym      (s_sym),
        .s_last     (s_last),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_freq  (core_freq),
        .core_cum   (core_cum),
        .core_first (core_first),
        .core_last  (core_last),
        .core_done  (core_done),
        .busy       (busy),
        .frame_len  (frame_len),
        .err_zero   (err_zero),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES:0]   freq;
        logic [RES-1:0] cum;
        logic           first;
        logic           last;
    } beat_t;

    typedef struct {
        logic [SW-1:0]  sym;
        logic [RES:0]   freq;
        logic [RES-1:0] cum;
    } vec_t;

    beat_t          q[$];
    logic [63:0]    xq[$];
    logic [SW-1:0]  syms[$];
    vec_t           vecs[6];
    logic [RES:0]   m_freq[256];
    logic [RES-1:0] m_cum[256];
    logic [63:0]    x_act = '0;
    int             n_tests = 0;
    int             n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rans_step(input logic [63:0] x, input logic [RES:0] f,
                                              input logic [RES-1:0] c);
        if (f == '0) return x;
        return ((x / 64'(f)) << 10) + (x % 64'(f)) + 64'(c);
    endfunction

    // Compare every presented beat against the head of the scoreboard; pop on handshake.
    always @(negedge clk) begin
        if (core_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got beat freq=%0d cum=%0d, required no beat (t=%0t)",
                         core_freq, core_cum, $time);
            end else begin
                check("beat_freq",  64'(core_freq),  64'(q[0].freq));
                check("beat_cum",   64'(core_cum),   64'(q[0].cum));
                check("beat_first", 64'(core_first), 64'(q[0].first));
                check("beat_last",  64'(core_last),  64'(q[0].last));
                if (core_ready) begin
                    x_act = rans_step(core_first ? X0 : x_act, core_freq, core_cum);
                    if (core_last && xq.size() != 0) begin
                        check("rans_state", x_act, xq.pop_front());
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic cfg_write(input logic [SW-1:0] sym, input logic [RES:0] f,
                             input logic [RES-1:0] c, input bit track);
        cfg_we = 1'b1; cfg_sym = sym; cfg_freq = f; cfg_cum = c;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (track) begin
            m_freq[sym] = f;
            m_cum[sym]  = c;
        end
    endtask

    task automatic send_beat(input logic [SW-1:0] sym, input logic last);
        int n = 0;
        s_valid = 1'b1; s_sym = sym; s_last = last;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready=0, required 1 within 200 cycles");
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] fs[$]);
        int          n = fs.size();
        bit          good = (n <= MF);
        logic [63:0] x = X0;
        beat_t       b;
        foreach (fs[i]) if (m_freq[fs[i]] == '0) good = 1'b0;
        if (good) begin
            for (int i = n - 1; i >= 0; i--) begin
                b.freq  = m_freq[fs[i]];
                b.cum   = m_cum[fs[i]];
                b.first = (i == n - 1);
                b.last  = (i == 0);
                q.push_back(b);
                x = rans_step(x, b.freq, b.cum);
            end
            xq.push_back(x);
        end
        foreach (fs[i]) send_beat(fs[i], i == n - 1);
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while ((q.size() != 0 || core_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_beats_left"}, 64'(q.size()), 64'd0);
        check({tag, "_wait_busy"}, 64'(busy), 64'd1);
        check({tag, "_wait_s_ready"}, 64'(s_ready), 64'd0);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_s_ready"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        vecs[0] = '{SYM_A, 11'd300,  10'd0};
        vecs[1] = '{SYM_B, 11'd200,  10'd300};
        vecs[2] = '{SYM_C, 11'd524,  10'd500};
        vecs[3] = '{SYM_D, 11'd0,    10'd0};
        vecs[4] = '{8'h00, 11'd1,    10'd1023};
        vecs[5] = '{8'hFF, 11'd1024, 10'd0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready",    64'(s_ready),    64'd1);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_core_freq",  64'(core_freq),  64'd0);
        check("rst_core_first", 64'(core_first), 64'd0);
        check("rst_core_last",  64'(core_last),  64'd0);
        check("rst_frame_len",  64'(frame_len),  64'd0);
        check("rst_err_zero",   64'(err_zero),   64'd0);
        check("rst_err_ovf",    64'(err_ovf),    64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) cfg_write(vecs[i].sym, vecs[i].freq, vecs[i].cum, 1'b1);

        // Single-symbol frames: one beat with first=last=1, or a silent discard.
        foreach (vecs[i]) begin
            if (vecs[i].freq != '0) begin
                b.freq = vecs[i].freq; b.cum = vecs[i].cum; b.first = 1'b1; b.last = 1'b1;
                q.push_back(b);
                xq.push_back(rans_step(X0, vecs[i].freq, vecs[i].cum));
            end
            send_beat(vecs[i].sym, 1'b1);
            check("vec_frame_len", 64'(frame_len), 64'd1);
            check("vec_err_zero", 64'(err_zero), 64'(vecs[i].freq == '0));
            if (vecs[i].freq != '0) finish_frame("vec");
            else check("vec_discard_busy", 64'(busy), 64'd0);
        end

        syms = '{SYM_A, SYM_B, SYM_C};
        send_frame(syms);
        check("abc_valid_next", 64'(core_valid), 64'd1);
        check("abc_first_next", 64'(core_first), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("abc_consecutive", 64'(q.size()), 64'd0);
        check("abc_frame_len", 64'(frame_len), 64'd3);
        finish_frame("abc");

        syms = '{SYM_A, SYM_C, SYM_B, SYM_C};
        send_frame(syms);
        @(posedge clk); #1;
        core_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("stall_valid", 64'(core_valid), 64'd1);
        check("stall_left", 64'(q.size()), 64'd3);
        core_ready = 1'b1;
        finish_frame("stall");

        send_beat(SYM_A, 1'b0);
        send_beat(SYM_D, 1'b0);
        check("zero_err_set", 64'(err_zero), 64'd1);
        check("zero_discard_busy", 64'(busy), 64'd1);
        check("zero_discard_ready", 64'(s_ready), 64'd1);
        send_beat(SYM_B, 1'b1);
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_err_sticky", 64'(err_zero), 64'd1);
        check("zero_frame_len", 64'(frame_len), 64'd3);
        syms = '{SYM_B};
        send_frame(syms);
        check("zero_cleared", 64'(err_zero), 64'd0);
        finish_frame("zero_next");

        for (int i = 0; i < MF + 1; i++) begin
            if (i == MF) begin
                check("ovf_before_flag", 64'(err_ovf), 64'd0);
                check("ovf_before_busy", 64'(busy), 64'd1);
            end
            send_beat(SYM_A, i == MF);
        end
        check("ovf_flag", 64'(err_ovf), 64'd1);
        check("ovf_idle", 64'(busy), 64'd0);
        check("ovf_frame_len", 64'(frame_len), 64'(MF + 1));

        syms.delete();
        for (int i = 0; i < MF; i++) syms.push_back(SYM_A + 8'(i % 3));
        send_frame(syms);
        check("full_frame_len", 64'(frame_len), 64'(MF));
        check("full_no_ovf", 64'(err_ovf), 64'd0);
        finish_frame("full");

        core_ready = 1'b0;
        syms = '{SYM_A, SYM_B};
        send_frame(syms);
        cfg_write(SYM_A, 11'd7, 10'd9, 1'b0);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        check("done_ignored_busy", 64'(busy), 64'd1);
        check("done_ignored_valid", 64'(core_valid), 64'd1);
        core_ready = 1'b1;
        finish_frame("cfg_drain");
        syms = '{SYM_A};
        send_frame(syms);
        finish_frame("cfg_old");

        // Write and lookup of the same entry in one cycle: the lookup sees the old value.
        cfg_we = 1'b1; cfg_sym = SYM_B; cfg_freq = 11'd100; cfg_cum = 10'd50;
        syms = '{SYM_B};
        send_frame(syms);
        cfg_we = 1'b0;
        finish_frame("wr_lookup_old");
        m_freq[SYM_B] = 11'd100;
        m_cum[SYM_B]  = 10'd50;
        send_frame(syms);
        finish_frame("wr_lookup_new");

        core_ready = 1'b0;
        syms = '{SYM_A, SYM_B, SYM_C};
        send_frame(syms);
        @(posedge clk); #1;
        check("rst_drain_valid_pre", 64'(core_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_drain_busy", 64'(busy), 64'd0);
        check("rst_drain_valid", 64'(core_valid), 64'd0);
        check("rst_drain_ready", 64'(s_ready), 64'd1);
        check("rst_drain_len", 64'(frame_len), 64'd0);
        q.delete();
        xq.delete();
        rst_n = 1'b1;
        core_ready = 1'b1;
        @(posedge clk); #1;
        syms = '{SYM_C};
        send_frame(syms);
        finish_frame("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
